mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage access controller between the execute/memory pipeline latch and the memory/writeback latch. It turns the latched load, store, LL and SC controls into a held data-cache request, and raises `stall_for_data` until `dhit`. It produces the word written back (load data or SC status) and owns the LL/SC link register, including snoop invalidation.

## Interface
- `LLSC_EN`, default 1: 1 enables LL/SC handling; 0 treats `ll_in` as a load and `sc_in` as a store, and the SC result is always 1.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `MemRead_in` in 1: the instruction in MEM is a load (`lw`).
- `MemWrite_in` in 1: the instruction in MEM is a store (`sw`).
- `ll_in` in 1: the instruction is LL; only valid with `MemRead_in`.
- `sc_in` in 1: the instruction is SC; only valid with `MemWrite_in`.
- `addr_in` in 32 (word_t): effective address (ALU result).
- `store_data_in` in 32: rt value to store.
- `advance_in` in 1: the EX/MEM latch loads a new instruction at the next edge.
- `dhit` in 1: the data cache completed the request this cycle.
- `dmemload` in 32: read data; valid when `dhit`.
- `snoop_inv` in 1: coherence invalidation this cycle.
- `snoop_addr` in 32: address of the invalidation.
- `dREN` out 1: data read request.
- `dWEN` out 1: data write request.
- `daddr` out 32: request address; equals `addr_in`.
- `dmemstore` out 32: store data; equals `store_data_in`.
- `stall_for_data` out 1: freezes the pipeline; also drives the memory/writeback latch hold input.
- `wdat_out` out 32: value for `wdat_in` of the memory/writeback latch.
- `link_valid` out 1: link register valid (debug).
- `miss_cycles` out 16: saturating count of stalled cycles.

## Operation
- The FSM is `mem_state_t`, with states IDLE and DONE.
- **IDLE, no memory op:** requests 0, stall 0, `wdat_out` = 0.
- **IDLE, load or store:** `dREN`/`dWEN` assert combinationally in the same cycle. `stall_for_data` = `!dhit`.
  - When `dhit` and `advance_in`: stay IDLE.
  - When `dhit` and not `advance_in`: go to DONE and capture `data_q`.
  - Without `dhit`: stay IDLE and hold the request. `dREN`, `dWEN`, `daddr` and `dmemstore` stay stable until `dhit`.
- **DONE:** the access already completed but the instruction is still held by another stall.
  - No requests, stall 0, `wdat_out` = `data_q`.
  - `advance_in` returns the FSM to IDLE.
  - Accesses are never reissued from DONE.
- **`wdat_out` in IDLE on `dhit`:** `dmemload` for a load; 1 for a successful SC; 0 for a plain store.
- **Both `MemRead_in` and `MemWrite_in` asserted:** write wins; the read is ignored.
- **LL on `dhit`:** `link_valid` ← 1 and `link_addr` ← `addr_in[31:2]`.
- **SC decision:** made in IDLE and combinational. `sc_ok` = `link_valid` && `addr_in[31:2]`==`link_addr` && !(`snoop_inv` && `snoop_addr[31:2]`==`link_addr`).
  - `sc_ok`: behaves as a store; on `dhit`, the result is 1 and the link is cleared.
  - `!sc_ok`: no request, stall 0, result 0, and the link is cleared at the edge. The FSM goes to DONE if `!advance_in`.
- **Link clearing:** the link is cleared by:
  - a local store completing (`dhit`) to `link_addr`;
  - `snoop_inv` with a matching word address, checked every cycle in any state.
- **Same-edge LL set and snoop clear:** the set wins, since the snoop predates the LL data.
- **`miss_cycles`:** +1 on every cycle with `stall_for_data`=1; saturates at 0xFFFF.

## Timing
- Latency: a hit in the same cycle gives zero stall cycles; a miss costs N stall cycles, where N is the number of cycles before `dhit`.
- Request outputs are Mealy in IDLE; `data_q`, `link_*`, state and counter are registered.
- Reset values:
  - state IDLE, `data_q` 0, `link_valid` 0, `link_addr` 0, `miss_cycles` 0;
  - `dREN`, `dWEN`, `stall_for_data`, `wdat_out` are all 0 while `RST` is high.
- Reset asserted mid-miss: the request drops asynchronously and no capture occurs; after release, an outstanding op reissues from IDLE.
- `advance_in` is ignored while `stall_for_data`=1. The hazard unit guarantees this; the bench asserts it.

## Structure
- `mem_state_t` goes in `cpu_types_pkg`, next to `word_t`.
- One sub-module, `llsc_link`, holds `link_valid`/`link_addr` with its set, clear and snoop-compare logic and outputs `sc_ok`. It is instantiated only when `LLSC_EN`=1; otherwise `sc_ok` = 1.
- The FSM, `data_q` and the counter stay in the top module.

## Test plan
- **Load miss:** lw to 0x100, `dhit` on the 3rd cycle with `dmemload` 0xDEADBEEF → `dREN` high for 3 cycles, stall 2 cycles, `wdat_out` 0xDEADBEEF on the hit cycle, `miss_cycles` 2.
- **Held instruction:** load hits while `advance_in`=0 for 2 cycles → DONE, no second `dREN`, `wdat_out` holds the data, IDLE after `advance_in`.
- **LL/SC success:** ll 0x200, then sc 0x200 (0x55) → `dWEN` with `dmemstore` 0x55, result 1, `link_valid` 0 afterwards.
- **SC failure:** ll 0x200, `snoop_inv` 0x200, sc 0x200 → no `dWEN`, result 0, stall 0. Repeat with the snoop in the same cycle as the SC → also fails.
- **Reset mid-miss:** assert `RST` during a sw wait → `dWEN` drops immediately, and all outputs and `miss_cycles` are 0.
- **Saturation:** hold a miss for 70000 cycles → `miss_cycles` sticks at 0xFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types.
//   word_t      - 32-bit machine word
//   mem_state_t - memory-stage access FSM state (IDLE / DONE)
//   MISS_MAX    - saturation value of the miss-cycle counter
//   wordMatch   - compares a byte address against a stored word address
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_DONE = 1'b1
  } mem_state_t;

  localparam logic [15:0] MISS_MAX = 16'hFFFF;

  // Byte-offset bits are ignored so that any byte of a linked word matches.
  function automatic logic wordMatch(input word_t addr, input logic [29:0] wordAddr);
    return addr[31:2] == wordAddr;
  endfunction

endpackage

// File: rtl/llsc_link.sv
// LL/SC link register with set, clear and snoop-compare logic.
// Ports:
//   clk_i, rst_i    - clock and asynchronous active-high reset
//   addr_i          - effective address of the instruction in MEM
//   setLink_i       - an LL completed this cycle; link addr_i
//   scResolve_i     - an SC resolved this cycle (success or failure)
//   storeHit_i      - a local store completed this cycle at addr_i
//   snoopInv_i      - coherence invalidation this cycle
//   snoopAddr_i     - address of the invalidation
//   linkValid_o     - link register valid
//   scOk_o          - an SC at addr_i would succeed this cycle
import cpu_types_pkg::*;

module llsc_link (
  input  logic  clk_i,
  input  logic  rst_i,
  input  word_t addr_i,
  input  logic  setLink_i,
  input  logic  scResolve_i,
  input  logic  storeHit_i,
  input  logic  snoopInv_i,
  input  word_t snoopAddr_i,
  output logic  linkValid_o,
  output logic  scOk_o
);

  logic        linkValid_q, linkValid_d;
  logic [29:0] linkAddr_q, linkAddr_d;
  logic        snoopHit;

  assign snoopHit    = snoopInv_i && wordMatch(snoopAddr_i, linkAddr_q);
  // A snoop landing in the same cycle as the SC already breaks atomicity.
  assign scOk_o      = linkValid_q && wordMatch(addr_i, linkAddr_q) && !snoopHit;
  assign linkValid_o = linkValid_q;

  // Clears are applied first so that an LL completing on the same edge as
  // a matching snoop still leaves the link set: the snoop predates the data.
  always_comb begin
    linkValid_d = linkValid_q;
    linkAddr_d  = linkAddr_q;
    if (snoopHit || scResolve_i || (storeHit_i && wordMatch(addr_i, linkAddr_q))) begin
      linkValid_d = 1'b0;
    end
    if (setLink_i) begin
      linkValid_d = 1'b1;
      linkAddr_d  = addr_i[31:2];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      linkValid_q <= 1'b0;
      linkAddr_q  <= '0;
    end else begin
      linkValid_q <= linkValid_d;
      linkAddr_q  <= linkAddr_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller between the EX/MEM and MEM/WB latches.
// Turns load/store/LL/SC controls into a held data-cache request, stalls
// the pipeline until dhit, produces the write-back word and owns the link.
// Ports:
//   CLK, RST                       - clock, asynchronous active-high reset
//   MemRead_in, MemWrite_in        - load / store in MEM
//   ll_in, sc_in                   - LL / SC qualifiers
//   addr_in, store_data_in         - effective address, store data
//   advance_in                     - EX/MEM loads a new instruction next edge
//   dhit, dmemload                 - cache completion and read data
//   snoop_inv, snoop_addr          - coherence invalidation
//   dREN, dWEN, daddr, dmemstore   - cache request
//   stall_for_data                 - pipeline freeze / MEM/WB hold
//   wdat_out                       - write-back value
//   link_valid                     - link register valid (debug)
//   miss_cycles                    - saturating stalled-cycle count
import cpu_types_pkg::*;

module mem_access_unit #(
  parameter logic LLSC_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        ll_in,
  input  logic        sc_in,
  input  word_t       addr_in,
  input  word_t       store_data_in,
  input  logic        advance_in,
  input  logic        dhit,
  input  word_t       dmemload,
  input  logic        snoop_inv,
  input  word_t       snoop_addr,
  output logic        dREN,
  output logic        dWEN,
  output word_t       daddr,
  output word_t       dmemstore,
  output logic        stall_for_data,
  output word_t       wdat_out,
  output logic        link_valid,
  output logic [15:0] miss_cycles
);

  mem_state_t  state_q, state_d;
  word_t       data_q, data_d;
  logic [15:0] missCycles_q;

  logic isWrite, isRead, isSc, isLl, scOk, scFail, complete, inIdle;

  // Write wins when both controls are set.
  assign isWrite = MemWrite_in;
  assign isRead  = MemRead_in && !MemWrite_in;
  assign isSc    = LLSC_EN && sc_in && isWrite;
  assign isLl    = LLSC_EN && ll_in && isRead;
  assign scFail  = isSc && !scOk;
  assign inIdle  = !RST && (state_q == MEM_IDLE);

  assign daddr       = addr_in;
  assign dmemstore   = store_data_in;
  assign miss_cycles = missCycles_q;

  // Mealy request/result logic. A failed SC completes immediately with
  // result 0 and never reaches the cache.
  always_comb begin
    dREN           = 1'b0;
    dWEN           = 1'b0;
    stall_for_data = 1'b0;
    wdat_out       = '0;
    complete       = 1'b0;
    if (!RST) begin
      if (state_q == MEM_DONE) begin
        wdat_out = data_q;
      end else if (scFail) begin
        complete = 1'b1;
      end else if (isRead || isWrite) begin
        dREN           = isRead;
        dWEN           = isWrite;
        stall_for_data = !dhit;
        complete       = dhit;
        if (dhit) begin
          wdat_out = isRead ? dmemload : {31'b0, sc_in};
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (state_q == MEM_IDLE) begin
      if (complete && !advance_in) begin
        state_d = MEM_DONE;
        data_d  = wdat_out;
      end
    end else if (advance_in) begin
      state_d = MEM_IDLE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= MEM_IDLE;
      data_q       <= '0;
      missCycles_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      if (stall_for_data && (missCycles_q != MISS_MAX)) begin
        missCycles_q <= missCycles_q + 16'd1;
      end
    end
  end

  generate
    if (LLSC_EN) begin : g_link
      llsc_link u_link (
        .clk_i       (CLK),
        .rst_i       (RST),
        .addr_i      (addr_in),
        .setLink_i   (inIdle && isLl && dhit),
        .scResolve_i (inIdle && isSc && complete),
        .storeHit_i  (dWEN && dhit),
        .snoopInv_i  (snoop_inv),
        .snoopAddr_i (snoop_addr),
        .linkValid_o (link_valid),
        .scOk_o      (scOk)
      );
    end else begin : g_nolink
      assign scOk       = 1'b1;
      assign link_valid = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead_in, MemWrite_in, ll_in, sc_in;
  logic [31:0] addr_in, store_data_in;
  logic        advance_in, dhit;
  logic [31:0] dmemload;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic        dREN, dWEN, stall_for_data, link_valid;
  logic [31:0] daddr, dmemstore, wdat_out;
  logic [15:0] miss_cycles;

  int checks = 0;
  int errors = 0;

  // Model state: whether the held instruction already finished its access,
  // the value it produced, the link, and the number of stalled cycles.
  bit          mHeld;
  logic [31:0] mData;
  bit          mLinkValid;
  logic [29:0] mLinkAddr;
  int          mMiss;

  bit          eRen, eWen, eStall, eDone;
  logic [31:0] eWdat;

  logic [31:0] addrPool [4] = '{32'h200, 32'h201, 32'h204, 32'h300};

  mem_access_unit dut (
    .CLK(CLK), .RST(RST),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ll_in(ll_in), .sc_in(sc_in),
    .addr_in(addr_in), .store_data_in(store_data_in),
    .advance_in(advance_in), .dhit(dhit), .dmemload(dmemload),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dmemstore(dmemstore),
    .stall_for_data(stall_for_data), .wdat_out(wdat_out),
    .link_valid(link_valid), .miss_cycles(miss_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    mHeld = 0; mData = '0; mLinkValid = 0; mLinkAddr = '0; mMiss = 0;
  endtask

  function automatic bit snoopHitsLink();
    return snoop_inv && (snoop_addr[31:2] == mLinkAddr);
  endfunction

  // Expected behaviour of the instruction in MEM for the current inputs.
  task automatic predict();
    bit rd, wr, sc, scOk;
    wr   = MemWrite_in;
    rd   = MemRead_in && !MemWrite_in;
    sc   = wr && sc_in;
    scOk = mLinkValid && (addr_in[31:2] == mLinkAddr) && !snoopHitsLink();
    eRen = 0; eWen = 0; eStall = 0; eDone = 0; eWdat = '0;
    if (mHeld) begin
      eWdat = mData;
    end else if (sc && !scOk) begin
      eDone = 1;
    end else if (rd || wr) begin
      eRen   = rd;
      eWen   = wr;
      eStall = !dhit;
      eDone  = dhit;
      if (dhit) eWdat = rd ? dmemload : (sc ? 32'd1 : 32'd0);
    end
  endtask

  task automatic updateModel();
    bit sc;
    sc = MemWrite_in && sc_in;
    if (eStall && mMiss < 65535) mMiss++;
    if (snoopHitsLink()) mLinkValid = 0;
    if (!mHeld && eDone && sc) mLinkValid = 0;
    if (eWen && dhit && addr_in[31:2] == mLinkAddr) mLinkValid = 0;
    if (eRen && dhit && ll_in) begin
      mLinkValid = 1;
      mLinkAddr  = addr_in[31:2];
    end
    if (mHeld) begin
      if (advance_in) mHeld = 0;
    end else if (eDone && !advance_in) begin
      mHeld = 1;
      mData = eWdat;
    end
  endtask

  // One clock: inputs were set after the previous edge; outputs are sampled
  // just before the next rising edge, then the model steps.
  task automatic stepCycle();
    @(negedge CLK);
    #4;
    predict();
    checkOutput("dREN", dREN, eRen);
    checkOutput("dWEN", dWEN, eWen);
    checkOutput("stall", stall_for_data, eStall);
    checkOutput("wdat", wdat_out, eWdat);
    checkOutput("linkValid", link_valid, mLinkValid);
    checkOutput("missCycles", miss_cycles, mMiss);
    checkOutput("daddr", daddr, addr_in);
    checkOutput("dmemstore", dmemstore, store_data_in);
    checkOutput("advDuringStall", advance_in && stall_for_data, 0);
    updateModel();
    @(posedge CLK);
    #1;
  endtask

  task automatic setOp(input bit rd, input bit wr, input bit ll, input bit sc,
                       input logic [31:0] addr, input logic [31:0] data);
    MemRead_in = rd; MemWrite_in = wr; ll_in = ll; sc_in = sc;
    addr_in = addr; store_data_in = data;
  endtask

  task automatic drive(input bit hit, input bit adv, input logic [31:0] load);
    dhit = hit; advance_in = adv; dmemload = load;
    stepCycle();
  endtask

  // Random traffic: a new instruction is chosen only after one advances;
  // dhit is offered only while a request is expected.
  task automatic applyStimulus(input int cycles);
    bit newInstr = 1;
    int op;
    for (int i = 0; i < cycles; i++) begin
      if (newInstr) begin
        op = $urandom_range(0, 5);
        setOp(op == 1 || op == 3 || op == 5, op == 2 || op == 4 || op == 5,
              op == 3, op == 4, addrPool[$urandom_range(0, 3)], $urandom);
      end
      snoop_inv  = ($urandom_range(0, 5) == 0);
      snoop_addr = addrPool[$urandom_range(0, 3)];
      dhit = 0;
      predict();
      if (eRen || eWen) dhit = ($urandom_range(0, 2) == 0);
      dmemload = $urandom;
      predict();
      advance_in = eStall ? 1'b0 : 1'($urandom_range(0, 1));
      newInstr = advance_in;
      stepCycle();
    end
  endtask

  initial begin
    RST = 1'b1;
    setOp(1, 0, 0, 0, 32'h100, 32'h0);
    dhit = 0; advance_in = 0; dmemload = '0; snoop_inv = 0; snoop_addr = '0;
    resetModel();
    @(posedge CLK); #1;
    checkOutput("rstRen", dREN, 0);
    checkOutput("rstStall", stall_for_data, 0);
    checkOutput("rstWdat", wdat_out, 0);
    checkOutput("rstMiss", miss_cycles, 0);
    checkOutput("rstLink", link_valid, 0);
    RST = 1'b0;

    // Load miss: hit on the third cycle.
    setOp(1, 0, 0, 0, 32'h100, 32'h0);
    drive(0, 0, 32'h0);
    drive(0, 0, 32'h0);
    drive(1, 1, 32'hDEADBEEF);
    checkOutput("loadMissCount", miss_cycles, 2);
    setOp(0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 1, 32'h0);

    // Held instruction: hit while not advancing, then two held cycles.
    setOp(1, 0, 0, 0, 32'h104, 32'h0);
    drive(1, 0, 32'h12345678);
    drive(0, 0, 32'h0);
    checkOutput("heldWdat", wdat_out, 32'h12345678);
    checkOutput("heldNoRen", dREN, 0);
    drive(0, 0, 32'h0);
    drive(0, 1, 32'h0);
    setOp(0, 0, 0, 0, 32'h0, 32'h0);
    drive(0, 1, 32'h0);

    // LL/SC success.
    setOp(1, 0, 1, 0, 32'h200, 32'h0);
    drive(1, 1, 32'hAAAA);
    checkOutput("llLink", link_valid, 1);
    setOp(0, 1, 0, 1, 32'h200, 32'h55);
    #1;
    checkOutput("scWen", dWEN, 1);
    checkOutput("scStore", dmemstore, 32'h55);
    drive(1, 1, 32'h0);
    checkOutput("scClearsLink", link_valid, 0);

    // SC failure after an earlier snoop.
    setOp(1, 0, 1, 0, 32'h200, 32'h0);
    drive(1, 1, 32'h0);
    setOp(0, 0, 0, 0, 32'h0, 32'h0);
    snoop_inv = 1; snoop_addr = 32'h200;
    drive(0, 1, 32'h0);
    snoop_inv = 0;
    checkOutput("snoopClears", link_valid, 0);
    setOp(0, 1, 0, 1, 32'h200, 32'h66);
    #1;
    checkOutput("scFailWen", dWEN, 0);
    checkOutput("scFailStall", stall_for_data, 0);
    checkOutput("scFailWdat", wdat_out, 0);
    drive(0, 1, 32'h0);

    // SC failure with the snoop in the same cycle.
    setOp(1, 0, 1, 0, 32'h200, 32'h0);
    drive(1, 1, 32'h0);
    setOp(0, 1, 0, 1, 32'h200, 32'h77);
    snoop_inv = 1; snoop_addr = 32'h203;
    #1;
    checkOutput("scSameSnoopWen", dWEN, 0);
    checkOutput("scSameSnoopWdat", wdat_out, 0);
    drive(0, 1, 32'h0);
    checkOutput("scSameSnoopLink", link_valid, 0);

    // LL completing alongside a matching snoop keeps the link.
    setOp(1, 0, 1, 0, 32'h204, 32'h0);
    snoop_addr = 32'h204;
    drive(1, 1, 32'h0);
    snoop_inv = 0;
    checkOutput("llBeatsSnoop", link_valid, 1);

    // Reset in the middle of a store miss.
    setOp(0, 1, 0, 0, 32'h300, 32'h99);
    drive(0, 0, 32'h0);
    drive(0, 0, 32'h0);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("midRstWen", dWEN, 0);
    checkOutput("midRstStall", stall_for_data, 0);
    checkOutput("midRstWdat", wdat_out, 0);
    checkOutput("midRstMiss", miss_cycles, 0);
    checkOutput("midRstLink", link_valid, 0);
    resetModel();
    @(posedge CLK); #1;
    RST = 1'b0;
    drive(0, 0, 32'h0);
    drive(1, 1, 32'h0);

    // Counter saturation on a long miss.
    setOp(1, 0, 0, 0, 32'h400, 32'h0);
    for (int i = 0; i < 66000; i++) drive(0, 0, 32'h0);
    checkOutput("missSaturated", miss_cycles, 16'hFFFF);
    drive(1, 1, 32'h1);

    applyStimulus(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
